// File: rtl/dm_pkg.sv
// Shared definitions for the multicycle data memory: access modes, FSM encoding
// and the wait-state counter width.
package dm_pkg;

    localparam logic [1:0] DM_WORD = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_BYTE = 2'b10;

    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        INIT = 2'b00,
        IDLE = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: merges store data into the old word, extracts and
// extends sub-word loads, and flags misaligned addresses for the given mode.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic        sgn,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        merged    = old_word;
        load_data = 32'h0;
        misalign  = 1'b0;
        half      = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        byte_sel  = old_word[{addr_lo, 3'b000} +: 8];
        case (mode)
            DM_WORD: begin
                misalign  = (addr_lo != 2'b00);
                merged    = wdata;
                load_data = old_word;
            end
            DM_HALF: begin
                misalign = addr_lo[0];
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
                load_data = sgn ? {{16{half[15]}}, half} : {16'h0, half};
            end
            DM_BYTE: begin
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                load_data = sgn ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            end
            default: begin
                // Illegal mode: the top level reports the error, nothing to do here.
                merged = old_word;
            end
        endcase
    end

endmodule

// File: rtl/dm_multicycle.sv
// Multicycle data memory with valid/ready request port, wait states, error responses
// and an optional post-reset clear sweep. Define DM_TRACE_EN to print committed stores.
module dm_multicycle
    import dm_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int WAIT_CYCLES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_mode,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    state_t state, state_nx;

    logic [IDX_W-1:0]  cnt;
    logic [WCNT_W-1:0] wcnt;
    logic              lat_we;
    logic              lat_sgn;
    logic [1:0]        lat_mode;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [31:0]      old_word;
    logic [31:0]      merged;
    logic [31:0]      load_data;
    logic             misalign;
    logic             range_err;
    logic             err;
    logic             accept;
    logic             commit;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so a request offered in any other state is
    // simply not taken and the requester must keep it up (or drop it) itself.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    assign idx       = lat_addr[ADDR_W-1:2];
    assign old_word  = mem[idx];
    assign range_err = |(lat_addr >> ADDR_W);
    assign err       = misalign || range_err || (lat_mode == 2'b11);
    assign commit    = (state == WAIT) && (wcnt == '0);

    dm_lane_unit u_lane (
        .mode      (lat_mode),
        .addr_lo   (lat_addr[1:0]),
        .sgn       (lat_sgn),
        .old_word  (old_word),
        .wdata     (lat_wdata),
        .merged    (merged),
        .load_data (load_data),
        .misalign  (misalign)
    );

    // WAIT lasts WAIT_CYCLES+1 cycles so a response appears WAIT_CYCLES+1 edges after accept.
    always_comb begin
        state_nx = state;
        case (state)
            INIT: if (cnt == IDX_W'(DEPTH - 1)) state_nx = IDLE;
            IDLE: if (accept)                   state_nx = WAIT;
            WAIT: if (wcnt == '0)               state_nx = RESP;
            RESP:                               state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= (CLEAR_ON_RESET != 0) ? INIT : IDLE;
            cnt        <= '0;
            wcnt       <= '0;
            lat_we     <= 1'b0;
            lat_sgn    <= 1'b0;
            lat_mode   <= DM_WORD;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            init_done  <= (state_nx != INIT);
            resp_valid <= commit;
            if (state == INIT) cnt <= cnt + 1'b1;
            if (accept) begin
                wcnt      <= WCNT_W'(WAIT_CYCLES);
                lat_we    <= req_we;
                lat_sgn   <= req_signed;
                lat_mode  <= req_mode;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end else if ((state == WAIT) && (wcnt != '0)) begin
                wcnt <= wcnt - 1'b1;
            end
            if (commit) begin
                resp_err   <= err;
                resp_rdata <= (err || lat_we) ? 32'h0 : load_data;
            end
        end
    end

    // Array has no reset; reset only steers the FSM back into the clear sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[cnt] <= 32'h0;
            end else if (commit && lat_we && !err) begin
                mem[idx] <= merged;
`ifdef DM_TRACE_EN
                $display("%d@%h: *%h <= %h", $time, 32'd0, {lat_addr[31:2], 2'b00}, merged);
`endif
            end
        end
    end

endmodule
